// File: rtl/crypto_op_scheduler_if.sv
// Host command/response bus and engine start/done lines of the crypto scheduler.
//   master: host + engine side (drives commands, done pulses, abort, rsp_ready)
//   slave : scheduler side (drives cmd_ready, starts, response, status)
interface crypto_op_scheduler_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_engine;
  logic [TAG_W-1:0] cmd_tag;
  logic [2:0]       eng_start;
  logic [2:0]       eng_done;
  logic             abort;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0]       rsp_engine;
  logic [1:0]       rsp_status;
  logic [CNT_W-1:0] fifo_count;
  logic             busy;

  modport master (
    output cmd_valid, cmd_engine, cmd_tag, eng_done, abort, rsp_ready,
    input  cmd_ready, eng_start, rsp_valid, rsp_tag, rsp_engine, rsp_status,
           fifo_count, busy
  );

  modport slave (
    input  cmd_valid, cmd_engine, cmd_tag, eng_done, abort, rsp_ready,
    output cmd_ready, eng_start, rsp_valid, rsp_tag, rsp_engine, rsp_status,
           fifo_count, busy
  );
endinterface

// File: rtl/crypto_op_scheduler.sv
// Crypto command scheduler: queues (engine, tag) commands from the host, issues them
// one at a time as a one-cycle start pulse to AES/SHA2/PRNG, waits for done or a
// timeout, and returns one response per command.
//   clock   : single clock, posedge
//   reset_n : async assert, synchronously released internally
//   bus     : slave side of crypto_op_scheduler_if (command, engine, response, status)
//
// state | meaning
// IDLE  | nothing in flight; pops the FIFO head when one is queued
// ISSUE | start pulse to the selected engine, timer cleared
// WAIT  | counting towards TIMEOUT, watching the selected engine's done
// RESP  | response presented until the host accepts it
module crypto_op_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input logic clock,
  input logic reset_n,
  crypto_op_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, nextState;
  logic [1:0]       rstSync;
  logic             rstN;
  logic [1:0]       engMem [DEPTH];
  logic [TAG_W-1:0] tagMem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count;
  logic [1:0]       curEngine, curStatus, nextStatus;
  logic [TAG_W-1:0] curTag;
  logic [TMR_W-1:0] timer;
  logic [2:0]       curOneHot;
  logic             cmdReady, push, pop, doneHit;

  // Assertion reaches every flop immediately; release is aligned to the clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rstSync <= 2'b00;
    else          rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  assign cmdReady = (count != CNT_W'(DEPTH)) && !bus.abort;
  assign push     = bus.cmd_valid && cmdReady;

  always_comb begin
    curOneHot = 3'b000;
    case (curEngine)
      2'd0:    curOneHot = 3'b001;
      2'd1:    curOneHot = 3'b010;
      2'd2:    curOneHot = 3'b100;
      default: curOneHot = 3'b000;
    endcase
  end

  // Done lines of the other engines are masked off.
  assign doneHit = |(bus.eng_done & curOneHot);

  always_comb begin
    nextState  = state;
    nextStatus = curStatus;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        // Abort wins over a pop: the queue is flushed instead.
        if (!bus.abort && count != '0) begin
          pop = 1'b1;
          if (engMem[rdPtr] == 2'd3) begin
            nextState  = RESP;
            nextStatus = ST_ILLEGAL;
          end else begin
            nextState  = ISSUE;
            nextStatus = ST_OK;
          end
        end
      end
      ISSUE: begin
        if (bus.abort) begin
          nextState  = RESP;
          nextStatus = ST_ABORT;
        end else begin
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (doneHit) begin
          nextState  = RESP;
          nextStatus = ST_OK;
        end else if (bus.abort) begin
          nextState  = RESP;
          nextStatus = ST_ABORT;
        end else if (timer == TMR_LAST) begin
          nextState  = RESP;
          nextStatus = ST_TIMEOUT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      curEngine <= 2'd0;
      curTag    <= '0;
      curStatus <= 2'd0;
      timer     <= '0;
    end else begin
      state     <= nextState;
      curStatus <= nextStatus;
      if (pop) begin
        curEngine <= engMem[rdPtr];
        curTag    <= tagMem[rdPtr];
      end
      // Only counts while staying in WAIT, so it never wraps.
      if (state == ISSUE)
        timer <= '0;
      else if (state == WAIT && nextState == WAIT)
        timer <= timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (bus.abort) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      engMem[wrPtr] <= bus.cmd_engine;
      tagMem[wrPtr] <= bus.cmd_tag;
    end
  end

  // Combinational from state so reset removes the pulse without waiting for a clock.
  assign bus.eng_start  = (state == ISSUE && !bus.abort) ? curOneHot : 3'b000;
  assign bus.cmd_ready  = cmdReady;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_tag    = curTag;
  assign bus.rsp_engine = curEngine;
  assign bus.rsp_status = curStatus;
  assign bus.fifo_count = count;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_crypto_op_scheduler.sv
module tb_crypto_op_scheduler;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 8;
  localparam int TIMEOUT = 16;
  // Edges from the push edge to rsp_valid for a command that times out:
  // start 1, WAIT entered at 2, TIMEOUT cycles of WAIT.
  localparam int TO_LAT  = TIMEOUT + 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   nChecks = 0;
  int   nFail = 0;
  int   startCount = 0;
  logic [2:0] lastStart = 3'b000;
  bit   prevNz = 1'b0;

  crypto_op_scheduler_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  crypto_op_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] engine;
    logic [7:0] tag;
    int         doneDelay;   // edges after start seen; -1 = never
    logic [2:0] doneMask;
    logic [1:0] expStatus;
    logic [2:0] expStart;
    int         expLat;      // edges from push edge to rsp_valid
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.eng_start != 3'b000) begin
      startCount++;
      lastStart = bus.eng_start;
      check("start_onehot", 32'($onehot(bus.eng_start)), 32'd1);
      check("start_width", 32'(prevNz), 32'd0);
    end
    prevNz = (bus.eng_start != 3'b000);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushCmd(input logic [1:0] eng, input logic [7:0] tag, input string nm);
    bus.cmd_valid  = 1'b1;
    bus.cmd_engine = eng;
    bus.cmd_tag    = tag;
    check({nm, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic handshake(input string nm);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({nm, "_rsp_dropped"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic waitRsp(input string nm);
    int n = 0;
    while (!bus.rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check({nm, "_rsp_seen"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic runVec(input vec_t v, input string nm);
    int cyc = 0;
    int doneCyc = -1;
    int lat = -1;
    int base = startCount;
    bit gotRsp = 1'b0;
    pushCmd(v.engine, v.tag, nm);
    while (!gotRsp && cyc < 40) begin
      tick();
      cyc++;
      bus.eng_done = 3'b000;
      if (bus.rsp_valid) begin
        gotRsp = 1'b1;
        lat = cyc;
      end else begin
        if (bus.eng_start != 3'b000 && v.doneDelay >= 0 && doneCyc < 0)
          doneCyc = cyc + v.doneDelay;
        if (cyc == doneCyc) bus.eng_done = v.doneMask;
      end
    end
    bus.eng_done = 3'b000;
    check({nm, "_latency"}, 32'(lat), 32'(v.expLat));
    check({nm, "_starts"}, 32'(startCount - base), (v.expStart != 3'b000) ? 32'd1 : 32'd0);
    if (v.expStart != 3'b000) check({nm, "_start_vec"}, 32'(lastStart), 32'(v.expStart));
    if (gotRsp) begin
      check({nm, "_tag"}, 32'(bus.rsp_tag), 32'(v.tag));
      check({nm, "_engine"}, 32'(bus.rsp_engine), 32'(v.engine));
      check({nm, "_status"}, 32'(bus.rsp_status), 32'(v.expStatus));
      check({nm, "_busy"}, 32'(bus.busy), 32'd1);
      handshake(nm);
      check({nm, "_idle"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    //         eng   tag    dly mask    st     start   lat
    vecs[0] = '{2'd0, 8'h5A, 3, 3'b001, 2'b00, 3'b001, 5};
    vecs[1] = '{2'd1, 8'h33, 1, 3'b010, 2'b00, 3'b010, 3};
    vecs[2] = '{2'd2, 8'hC4, 5, 3'b100, 2'b00, 3'b100, 7};
    vecs[3] = '{2'd1, 8'h11, -1, 3'b000, 2'b01, 3'b010, TO_LAT};
    vecs[4] = '{2'd3, 8'h22, -1, 3'b000, 2'b10, 3'b000, 1};
    vecs[5] = '{2'd0, 8'h77, 2, 3'b110, 2'b01, 3'b001, TO_LAT};
    vecs[6] = '{2'd2, 8'h99, 1, 3'b111, 2'b00, 3'b100, 3};
    vecs[7] = '{2'd0, 8'h0F, 0, 3'b001, 2'b01, 3'b001, TO_LAT};

    bus.cmd_valid  = 1'b0;
    bus.cmd_engine = 2'd0;
    bus.cmd_tag    = '0;
    bus.eng_done   = 3'b000;
    bus.abort      = 1'b0;
    bus.rsp_ready  = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_eng_start", 32'(bus.eng_start), 32'd0);
    check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    check("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 8; i++) runVec(vecs[i], $sformatf("v%0d", i));

    // Late done after a timeout is ignored.
    runVec(vecs[3], "t3");
    base = startCount;
    bus.eng_done = 3'b010;
    tick();
    bus.eng_done = 3'b000;
    tick();
    check("t3_late_busy", 32'(bus.busy), 32'd0);
    check("t3_late_rsp", 32'(bus.rsp_valid), 32'd0);
    check("t3_late_starts", 32'(startCount - base), 32'd0);

    // Fill: 1 in flight + DEPTH queued, host not taking responses.
    for (int i = 0; i < 5; i++) pushCmd(2'd0, 8'hA0 + 8'(i), "t2_push");
    check("t2_full_count", 32'(bus.fifo_count), 32'd4);
    check("t2_full_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_tag   = 8'hAF;
    repeat (3) tick();
    bus.cmd_valid = 1'b0;
    check("t2_no_push_full", 32'(bus.fifo_count), 32'd4);
    for (int k = 0; k < 5; k++) begin
      waitRsp("t2");
      check("t2_order_tag", 32'(bus.rsp_tag), 32'hA0 + 32'(k));
      check("t2_status", 32'(bus.rsp_status), 32'd1);
      handshake("t2");
      check("t2_gap_no_start", 32'(bus.eng_start), 32'd0);
      if (k < 4) begin
        tick();
        check("t2_next_start", 32'(bus.eng_start), 32'b001);
        check("t2_count", 32'(bus.fifo_count), 32'(3 - k));
      end
    end
    tick();
    check("t2_end_busy", 32'(bus.busy), 32'd0);
    check("t2_end_count", 32'(bus.fifo_count), 32'd0);

    // Abort during WAIT with two PRNG commands queued behind.
    base = startCount;
    pushCmd(2'd2, 8'hB0, "t5");
    pushCmd(2'd2, 8'hB1, "t5");
    pushCmd(2'd2, 8'hB2, "t5");
    check("t5_count_before", 32'(bus.fifo_count), 32'd2);
    bus.abort      = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_tag    = 8'hBF;
    #1;
    check("t5_ready_abort", 32'(bus.cmd_ready), 32'd0);
    tick();
    bus.abort     = 1'b0;
    bus.cmd_valid = 1'b0;
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t5_status", 32'(bus.rsp_status), 32'd3);
    check("t5_tag", 32'(bus.rsp_tag), 32'hB0);
    check("t5_count", 32'(bus.fifo_count), 32'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_resp_kept", 32'(bus.rsp_valid), 32'd1);
    check("t5_resp_status_kept", 32'(bus.rsp_status), 32'd3);
    handshake("t5");
    repeat (8) tick();
    check("t5_starts", 32'(startCount - base), 32'd1);
    check("t5_idle", 32'(bus.busy), 32'd0);

    // Abort in ISSUE suppresses the start.
    base = startCount;
    pushCmd(2'd0, 8'hC0, "iss");
    tick();
    check("iss_start_visible", 32'(bus.eng_start), 32'b001);
    bus.abort = 1'b1;
    #1;
    check("iss_start_suppressed", 32'(bus.eng_start), 32'd0);
    tick();
    bus.abort = 1'b0;
    check("iss_status", 32'(bus.rsp_status), 32'd3);
    check("iss_tag", 32'(bus.rsp_tag), 32'hC0);
    handshake("iss");
    check("iss_starts", 32'(startCount - base), 32'd0);

    // Abort in IDLE beats a pending pop.
    base = startCount;
    pushCmd(2'd3, 8'hD0, "idl");
    pushCmd(2'd0, 8'hD1, "idl");
    handshake("idl");
    check("idl_count_before", 32'(bus.fifo_count), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idl_flushed", 32'(bus.fifo_count), 32'd0);
    check("idl_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    check("idl_starts", 32'(startCount - base), 32'd0);

    // Reset during WAIT with one command queued.
    base = startCount;
    pushCmd(2'd0, 8'hE0, "t6");
    pushCmd(2'd0, 8'hE1, "t6");
    tick();
    check("t6_busy_before", 32'(bus.busy), 32'd1);
    check("t6_count_before", 32'(bus.fifo_count), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_busy", 32'(bus.busy), 32'd0);
    check("t6_async_count", 32'(bus.fifo_count), 32'd0);
    check("t6_async_rsp", 32'(bus.rsp_valid), 32'd0);
    check("t6_async_start", 32'(bus.eng_start), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) tick();
    check("t6_post_busy", 32'(bus.busy), 32'd0);
    check("t6_post_count", 32'(bus.fifo_count), 32'd0);
    check("t6_post_starts", 32'(startCount - base), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
